cursor_ctrl_2d: RTL and testbench

Two-dimensional cursor controller for the VT52 terminal core. It is the successor to the single-axis cursor position register. It holds column and row, and executes cursor-motion commands from the escape-sequence decoder: relative moves, home, CR, LF, reverse LF, tab, direct addressing and post-character advance. It clamps at the screen edges. When a line feed runs off the bottom or a reverse line feed runs off the top, it asks the video RAM block to scroll through a req/ack handshake.

---
 rtl/cursor_ctrl_2d.sv | 167 ++++++++++++++++
 tb/tb_cursor_ctrl_2d.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cursor_ctrl_2d.sv
// VT52 two-axis cursor controller with clamped motion and scroll handshake.
// Define AUTOWRAP_EN to make ADVANCE at the last column wrap to a new line.
module cursor_ctrl_2d #(
    parameter int COLS      = 80,
    parameter int ROWS      = 24,
    parameter int COL_BITS  = 7,
    parameter int ROW_BITS  = 5,
    parameter int TAB_WIDTH = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [3:0]          cmd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [COL_BITS-1:0] set_col,
    input  logic [ROW_BITS-1:0] set_row,
    output logic [COL_BITS-1:0] col,
    output logic [ROW_BITS-1:0] row,
    output logic                scroll_req,
    output logic                scroll_dir,
    input  logic                scroll_ack
);

    typedef enum logic {
        IDLE,
        SCROLL
    } state_t;

    typedef enum logic [3:0] {
        C_NOP   = 4'd0,
        C_LEFT  = 4'd1,
        C_RIGHT = 4'd2,
        C_UP    = 4'd3,
        C_DOWN  = 4'd4,
        C_HOME  = 4'd5,
        C_CR    = 4'd6,
        C_LF    = 4'd7,
        C_RLF   = 4'd8,
        C_TAB   = 4'd9,
        C_SET   = 4'd10,
        C_ADV   = 4'd11
    } cmd_t;

    localparam logic [COL_BITS:0] COL_MAX  = (COL_BITS+1)'(COLS - 1);
    localparam logic [ROW_BITS:0] ROW_MAX  = (ROW_BITS+1)'(ROWS - 1);
    localparam logic [COL_BITS:0] TAB_STEP = (COL_BITS+1)'(TAB_WIDTH);
    localparam logic [COL_BITS:0] TAB_MASK = ~((COL_BITS+1)'(TAB_WIDTH - 1));

    function automatic logic [COL_BITS-1:0] clamp_col(input logic [COL_BITS:0] v);
        return (v > COL_MAX) ? COL_MAX[COL_BITS-1:0] : v[COL_BITS-1:0];
    endfunction

    function automatic logic [ROW_BITS-1:0] clamp_row(input logic [ROW_BITS:0] v);
        return (v > ROW_MAX) ? ROW_MAX[ROW_BITS-1:0] : v[ROW_BITS-1:0];
    endfunction

    state_t state;

    logic [COL_BITS:0]   col_w;
    logic [ROW_BITS:0]   row_w;
    logic [COL_BITS-1:0] col_inc;
    logic [COL_BITS-1:0] col_dec;
    logic [COL_BITS-1:0] col_tab;
    logic [ROW_BITS-1:0] row_inc;
    logic [ROW_BITS-1:0] row_dec;
    logic                at_last_col;
    logic                at_last_row;
    logic                at_top_row;

    logic [COL_BITS-1:0] nxt_col;
    logic [ROW_BITS-1:0] nxt_row;
    logic                nxt_scroll;
    logic                nxt_dir;

    // One spare bit keeps +1 and the tab step from wrapping before the clamp.
    assign col_w       = {1'b0, col};
    assign row_w       = {1'b0, row};
    assign col_inc     = clamp_col(col_w + 1'b1);
    assign row_inc     = clamp_row(row_w + 1'b1);
    assign col_dec     = (col == '0) ? '0 : col - 1'b1;
    assign row_dec     = (row == '0) ? '0 : row - 1'b1;
    assign col_tab     = clamp_col((col_w & TAB_MASK) + TAB_STEP);
    assign at_last_col = (col_w == COL_MAX);
    assign at_last_row = (row_w == ROW_MAX);
    assign at_top_row  = (row == '0);

    always_comb begin
        nxt_col    = col;
        nxt_row    = row;
        nxt_scroll = 1'b0;
        nxt_dir    = 1'b0;
        case (cmd)
            C_LEFT:  nxt_col = col_dec;
            C_RIGHT: nxt_col = col_inc;
            C_UP:    nxt_row = row_dec;
            C_DOWN:  nxt_row = row_inc;
            C_HOME: begin
                nxt_col = '0;
                nxt_row = '0;
            end
            C_CR:    nxt_col = '0;
            C_LF: begin
                if (at_last_row) nxt_scroll = 1'b1;
                else             nxt_row    = row_inc;
            end
            C_RLF: begin
                nxt_dir = 1'b1;
                if (at_top_row) nxt_scroll = 1'b1;
                else            nxt_row    = row_dec;
            end
            C_TAB:   nxt_col = col_tab;
            C_SET: begin
                nxt_col = clamp_col({1'b0, set_col});
                nxt_row = clamp_row({1'b0, set_row});
            end
            C_ADV: begin
`ifdef AUTOWRAP_EN
                if (at_last_col) begin
                    nxt_col = '0;
                    if (at_last_row) nxt_scroll = 1'b1;
                    else             nxt_row    = row_inc;
                end else begin
                    nxt_col = col_inc;
                end
`else
                nxt_col = at_last_col ? col : col_inc;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            scroll_req <= 1'b0;
            scroll_dir <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        col <= nxt_col;
                        row <= nxt_row;
                        if (nxt_scroll) begin
                            state      <= SCROLL;
                            scroll_req <= 1'b1;
                            scroll_dir <= nxt_dir;
                            cmd_ready  <= 1'b0;
                        end
                    end
                end
                SCROLL: begin
                    if (scroll_ack) begin
                        state      <= IDLE;
                        scroll_req <= 1'b0;
                        cmd_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_ctrl_2d.sv
// Bench for cursor_ctrl_2d: directed plan plus random commands vs. an
// integer-arithmetic reference model.
module tb_cursor_ctrl_2d;

    localparam int COLS = 80;
    localparam int ROWS = 24;
    localparam int CB   = 7;
    localparam int RB   = 5;
    localparam int TW   = 8;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [3:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CB-1:0] set_col = '0;
    logic [RB-1:0] set_row = '0;
    logic [CB-1:0] col;
    logic [RB-1:0] row;
    logic          scroll_req;
    logic          scroll_dir;
    logic          scroll_ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int m_col, m_row, m_dir;
    bit m_scroll;

    cursor_ctrl_2d #(
        .COLS(COLS), .ROWS(ROWS), .COL_BITS(CB), .ROW_BITS(RB), .TAB_WIDTH(TW)
    ) dut (
        .clk(clk), .clr(clr), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .set_col(set_col), .set_row(set_row),
        .col(col), .row(row), .scroll_req(scroll_req),
        .scroll_dir(scroll_dir), .scroll_ack(scroll_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_col = 0; m_row = 0; m_dir = 0; m_scroll = 0;
    endtask

    task automatic model_lf();
        if (m_row < ROWS - 1) m_row++;
        else begin m_scroll = 1; m_dir = 0; end
    endtask

    task automatic model_cmd(input int c, input int sc, input int sr);
        case (c)
            1:  m_col = imax(m_col - 1, 0);
            2:  m_col = imin(m_col + 1, COLS - 1);
            3:  m_row = imax(m_row - 1, 0);
            4:  m_row = imin(m_row + 1, ROWS - 1);
            5:  begin m_col = 0; m_row = 0; end
            6:  m_col = 0;
            7:  model_lf();
            8:  if (m_row > 0) m_row--;
                else begin m_scroll = 1; m_dir = 1; end
            9:  m_col = imin((m_col / TW + 1) * TW, COLS - 1);
            10: begin m_col = imin(sc, COLS - 1); m_row = imin(sr, ROWS - 1); end
            11: begin
`ifdef AUTOWRAP_EN
                if (m_col == COLS - 1) begin m_col = 0; model_lf(); end
                else m_col++;
`else
                m_col = imin(m_col + 1, COLS - 1);
`endif
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".col"}, int'(col), m_col);
        check({tag, ".row"}, int'(row), m_row);
        check({tag, ".req"}, int'(scroll_req), int'(m_scroll));
        check({tag, ".rdy"}, int'(cmd_ready), int'(!m_scroll));
        if (m_scroll) check({tag, ".dir"}, int'(scroll_dir), m_dir);
    endtask

    // Called at a negedge: drive, advance model, clock, compare at next negedge.
    task automatic step(input string tag, input bit v, input int c,
                        input int sc, input int sr, input bit ack);
        cmd_valid  = v;
        cmd        = 4'(c);
        set_col    = CB'(sc);
        set_row    = RB'(sr);
        scroll_ack = ack;
        if (!m_scroll) begin
            if (v) model_cmd(c, sc, sr);
        end else if (ack) begin
            m_scroll = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        clr = 1'b0;

        step("set_clamp", 1, 10, 100, 30, 0);
        step("home", 1, 5, 0, 0, 0);
        step("left0", 1, 1, 0, 0, 0);
        step("up0", 1, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("tab", 1, 9, 0, 0, 0);
        check("tab24", int'(col), 24);
        step("set78", 1, 10, 78, 0, 0);
        step("tab_clamp", 1, 9, 0, 0, 0);
        check("tab79", int'(col), 79);
        step("tab_stay", 1, 9, 0, 0, 0);

        step("set_bot", 1, 10, 0, 23, 0);
        step("lf_scroll", 1, 7, 0, 0, 0);
        check("lf_req", int'(scroll_req), 1);
        for (int i = 0; i < 5; i++) step("scroll_hold", 1, 2, 0, 0, 0);
        step("ack", 0, 0, 0, 0, 1);
        step("after_ack", 0, 0, 0, 0, 1);
        step("idle_ack", 0, 0, 0, 0, 1);

        step("set_top", 1, 10, 5, 0, 0);
        step("rlf_scroll", 1, 8, 0, 0, 0);
        check("rlf_dir", int'(scroll_dir), 1);
        #2 clr = 1'b1;
        #1;
        model_reset();
        check_all("clr_mid");
        @(negedge clk);
        scroll_ack = 1'b1;
        @(negedge clk);
        check_all("clr_hold");
        clr = 1'b0;

        step("home2", 1, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("b2b_right", 1, 2, 0, 0, 0);
        check("b2b_col4", int'(col), 4);
        for (int c = 12; c < 16; c++) step("unused", 1, c, 0, 0, 0);

        step("set79_5", 1, 10, 79, 5, 0);
        step("adv_mid", 1, 11, 0, 0, 0);
        step("set79_23", 1, 10, 79, 23, 0);
        step("adv_bot", 1, 11, 0, 0, 0);
        step("adv_ack", 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            int c, sc, sr;
            bit v, a;
            c  = ($urandom_range(0, 5) == 0) ? 10 : $urandom_range(0, 15);
            sc = $urandom_range(0, (1 << CB) - 1);
            sr = $urandom_range(0, (1 << RB) - 1);
            v  = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0);
            step("rand", v, c, sc, sr, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
